qpp_init_calc: RTL and testbench

- Upstream stage of the turbo-decoder read-address calculator.
- On a start request it computes the per-decoder starting QPP interleaver state for up to 8 parallel SISO decoders:
  - interleaved address pi(x) and increment g(x), each split into row (R) and bank (Q);
  - the constant step 2·f2 mod K, split the same way.
- Results are held stable and announced with a one-cycle Init_flag, which the address calculator uses to load its recursive pi += g, g += 2f2 engines.

---
 rtl/qpp_init_calc_pkg.sv | 83 ++++++++
 rtl/qpp_init_calc_modmul.sv | 64 ++++++
 rtl/qpp_init_calc.sv | 175 +++++++++++++++++
 tb/tb_qpp_init_calc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpp_init_calc_pkg.sv
// qpp_init_calc_pkg
//   Shared definitions for the QPP interleaver start-state calculator.
//   - ADDR_W / MAX_DEC / Q_W sizing constants
//   - FSM state encoding
//   - decNum decode (legal decoder count -> log2 shift)
//   - modular add (single conditional subtract) and the R/Q split helper
package qpp_init_calc_pkg;

  localparam int ADDR_W  = 13;
  localparam int MAX_DEC = 8;
  localparam int Q_W     = 3;
  localparam int QV_W    = Q_W * MAX_DEC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_S2F2,
    S_MUL1,
    S_MUL2,
    S_SPLIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] sh;
  } dec_t;

  typedef struct packed {
    logic [Q_W-1:0]    q;
    logic [ADDR_W-1:0] r;
  } split_t;

  // Only powers of two up to 8 are legal; they map to the M = K >> sh shift.
  function automatic dec_t dec_decode(input logic [3:0] d);
    dec_t o;
    o.ok = 1'b1;
    o.sh = 2'd0;
    case (d)
      4'd1:    o.sh = 2'd0;
      4'd2:    o.sh = 2'd1;
      4'd4:    o.sh = 2'd2;
      4'd8:    o.sh = 2'd3;
      default: o.ok = 1'b0;
    endcase
    return o;
  endfunction

  // (a + b) mod k, valid only when both operands are already < k.
  function automatic logic [ADDR_W-1:0] add_mod(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k})
      s = s - {1'b0, k};
    return s[ADDR_W-1:0];
  endfunction

  // Q = count of j in 1..7 with v >= j*M; R = v - Q*M. Multiples are built by
  // repeated addition; since they grow monotonically the last one passed is Q*M.
  function automatic split_t split_val(input logic [ADDR_W-1:0] v,
                                       input logic [ADDR_W-1:0] m);
    split_t          o;
    logic [ADDR_W+2:0] mult;
    logic [ADDR_W+2:0] qm;
    logic [ADDR_W+2:0] diff;
    mult = '0;
    qm   = '0;
    o.q  = '0;
    for (int j = 1; j < MAX_DEC; j++) begin
      mult = mult + {3'b000, m};
      if ({3'b000, v} >= mult) begin
        o.q = o.q + 3'd1;
        qm  = mult;
      end
    end
    diff = {3'b000, v} - qm;
    o.r  = diff[ADDR_W-1:0];
    return o;
  endfunction

endpackage

// File: rtl/qpp_init_calc_modmul.sv
// qpp_modmul_serial
//   Serial modular multiplier, result = (a * b) mod K, MSB-first
//   double-and-add, fixed ADDR_W-cycle latency.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     go          one-cycle start; the first step is performed in this cycle
//     a, b, K     operands (a, b < K); a and b are captured on go
//     result      accumulator; holds the product after the done cycle's edge
//     done        high in the cycle performing the final step
module qpp_modmul_serial
  import qpp_init_calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  input  logic [ADDR_W-1:0] K,
  output logic [ADDR_W-1:0] result,
  output logic              done
);

  localparam int CNT_W = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ADDR_W - 1);

  logic [ADDR_W-1:0] acc_reg, a_reg, b_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              run_reg;

  logic              active;
  logic [ADDR_W-1:0] a_cur, b_cur, acc_cur, dbl, acc_next;
  logic [CNT_W-1:0]  idx;

  // On go the step works straight from the ports so no load cycle is lost.
  always_comb begin
    active   = go | run_reg;
    a_cur    = go ? a : a_reg;
    b_cur    = go ? b : b_reg;
    acc_cur  = go ? '0 : acc_reg;
    idx      = go ? '0 : cnt_reg;
    dbl      = add_mod(acc_cur, acc_cur, K);
    acc_next = b_cur[ADDR_W-1] ? add_mod(dbl, a_cur, K) : dbl;
    done     = active && (idx == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (active) begin
      acc_reg <= acc_next;
      a_reg   <= a_cur;
      b_reg   <= b_cur << 1;
      cnt_reg <= idx + 1'b1;
      run_reg <= ~done;
    end
  end

  assign result = acc_reg;

endmodule

// File: rtl/qpp_init_calc.sv
// qpp_init_calc
//   Computes the starting QPP interleaver state (pi, g, 2f2, split into row R
//   and bank Q) for up to MAX_DEC parallel SISO decoders and announces it with
//   a one-cycle Init_flag.
//   Ports:
//     clk, reset                         clock / asynchronous active-high reset
//     start                              request, sampled only when idle
//     frameLen, decNum, f1, f2, startIdx K, decoder count, QPP coefs, x0
//     busy                               run in progress
//     cfg_err                            pulse: illegal decNum rejected
//     Init_flag                          pulse: results valid
//     blockSize, Req_A_Init              M and x0
//     Req_Rf_Init, Req_Qf_Init           pi(x0) mod M, per-decoder pi div M
//     Req_Rg_Init, Req_Qg_Init           g(x0) mod M, per-decoder g div M
//     Rf2, Qf2                           (2f2 mod K) split by M
module qpp_init_calc
  import qpp_init_calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frameLen,
  input  logic [3:0]        decNum,
  input  logic [ADDR_W-1:0] f1,
  input  logic [ADDR_W-1:0] f2,
  input  logic [ADDR_W-1:0] startIdx,
  output logic              busy,
  output logic              cfg_err,
  output logic              Init_flag,
  output logic [ADDR_W-1:0] blockSize,
  output logic [ADDR_W-1:0] Req_A_Init,
  output logic [ADDR_W-1:0] Req_Rf_Init,
  output logic [QV_W-1:0]   Req_Qf_Init,
  output logic [ADDR_W-1:0] Req_Rg_Init,
  output logic [QV_W-1:0]   Req_Qg_Init,
  output logic [ADDR_W-1:0] Rf2,
  output logic [Q_W-1:0]    Qf2
);

  state_t            state_reg;
  logic [ADDR_W-1:0] k_len_reg, f1_reg, f2_reg, m_reg, x_reg, t_reg;
  logic [3:0]        dec_reg;
  logic [1:0]        sh_reg;
  logic [2:0]        k_reg;
  logic              go_reg;

  dec_t              dec_info;
  logic [ADDR_W-1:0] mul_a, mul_result, g_val;
  logic              mul_done;
  split_t            sp_pi, sp_g, sp_f2;

  // MUL1 computes t = f2*x; MUL2 computes pi = ((f1 + t) mod K) * x. In the
  // first MUL2 cycle the multiplier still holds t, which the multiplier
  // captures together with the operand.
  always_comb begin
    dec_info = dec_decode(decNum);
    mul_a    = (state_reg == S_MUL1) ? f2_reg : add_mod(f1_reg, mul_result, k_len_reg);
    g_val    = add_mod(add_mod(add_mod(f1_reg, f2_reg, k_len_reg), t_reg, k_len_reg),
                       t_reg, k_len_reg);
    sp_pi    = split_val(mul_result, m_reg);
    sp_g     = split_val(g_val, m_reg);
    sp_f2    = split_val(add_mod(f2_reg, f2_reg, k_len_reg), m_reg);
  end

  qpp_modmul_serial u_mul (
    .clk    (clk),
    .reset  (reset),
    .go     (go_reg),
    .a      (mul_a),
    .b      (x_reg),
    .K      (k_len_reg),
    .result (mul_result),
    .done   (mul_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      k_len_reg   <= '0;
      f1_reg      <= '0;
      f2_reg      <= '0;
      m_reg       <= '0;
      x_reg       <= '0;
      t_reg       <= '0;
      dec_reg     <= '0;
      sh_reg      <= '0;
      k_reg       <= '0;
      go_reg      <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      Init_flag   <= 1'b0;
      blockSize   <= '0;
      Req_A_Init  <= '0;
      Req_Rf_Init <= '0;
      Req_Qf_Init <= '0;
      Req_Rg_Init <= '0;
      Req_Qg_Init <= '0;
      Rf2         <= '0;
      Qf2         <= '0;
    end else begin
      go_reg    <= 1'b0;
      cfg_err   <= 1'b0;
      Init_flag <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (dec_info.ok) begin
              k_len_reg  <= frameLen;
              f1_reg     <= f1;
              f2_reg     <= f2;
              dec_reg    <= decNum;
              sh_reg     <= dec_info.sh;
              Req_A_Init <= startIdx;
              busy       <= 1'b1;
              state_reg  <= S_SETUP;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          m_reg       <= k_len_reg >> sh_reg;
          blockSize   <= k_len_reg >> sh_reg;
          x_reg       <= Req_A_Init;
          k_reg       <= '0;
          Req_Qf_Init <= '0;
          Req_Qg_Init <= '0;
          state_reg   <= S_S2F2;
        end
        S_S2F2: begin
          Rf2       <= sp_f2.r;
          Qf2       <= sp_f2.q;
          go_reg    <= 1'b1;
          state_reg <= S_MUL1;
        end
        S_MUL1: begin
          if (mul_done) begin
            go_reg    <= 1'b1;
            state_reg <= S_MUL2;
          end
        end
        S_MUL2: begin
          if (go_reg)
            t_reg <= mul_result;
          if (mul_done)
            state_reg <= S_SPLIT;
        end
        S_SPLIT: begin
          Req_Qf_Init[k_reg*Q_W +: Q_W] <= sp_pi.q;
          Req_Qg_Init[k_reg*Q_W +: Q_W] <= sp_g.q;
          // R is identical for every decoder (contention-free QPP), keep k=0 only.
          if (k_reg == 3'd0) begin
            Req_Rf_Init <= sp_pi.r;
            Req_Rg_Init <= sp_g.r;
          end
          x_reg <= x_reg + m_reg;
          k_reg <= k_reg + 3'd1;
          if ({1'b0, k_reg} == dec_reg - 4'd1) begin
            state_reg <= S_DONE;
          end else begin
            go_reg    <= 1'b1;
            state_reg <= S_MUL1;
          end
        end
        S_DONE: begin
          Init_flag <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpp_init_calc.sv
// tb_qpp_init_calc
//   Directed table-driven bench for qpp_init_calc, plus hand-written sequences
//   for rejected configurations, start-while-busy and mid-run reset.
module tb_qpp_init_calc;
  import qpp_init_calc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] frameLen, f1, f2, startIdx;
  logic [3:0]        decNum;
  logic              busy, cfg_err, Init_flag;
  logic [ADDR_W-1:0] blockSize, Req_A_Init, Req_Rf_Init, Req_Rg_Init, Rf2;
  logic [QV_W-1:0]   Req_Qf_Init, Req_Qg_Init;
  logic [Q_W-1:0]    Qf2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qpp_init_calc dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frameLen    (frameLen),
    .decNum      (decNum),
    .f1          (f1),
    .f2          (f2),
    .startIdx    (startIdx),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .Init_flag   (Init_flag),
    .blockSize   (blockSize),
    .Req_A_Init  (Req_A_Init),
    .Req_Rf_Init (Req_Rf_Init),
    .Req_Qf_Init (Req_Qf_Init),
    .Req_Rg_Init (Req_Rg_Init),
    .Req_Qg_Init (Req_Qg_Init),
    .Rf2         (Rf2),
    .Qf2         (Qf2)
  );

  typedef struct {
    int          kk, f1, f2, dec, x0;
    int          rf, rg, rf2, qf2, bs;
    logic [23:0] qf, qg;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference QPP model using plain integer division.
  function automatic vec_t model(input int kk, input int cf1, input int cf2,
                                 input int dec, input int x0);
    vec_t    v;
    longint  x, pi, g, m;
    v.kk = kk; v.f1 = cf1; v.f2 = cf2; v.dec = dec; v.x0 = x0;
    m = kk / dec;
    v.bs = int'(m);
    v.qf = '0;
    v.qg = '0;
    v.rf = 0;
    v.rg = 0;
    for (int k = 0; k < dec; k++) begin
      x  = longint'(x0) + longint'(k) * m;
      pi = (longint'(cf1) * x + longint'(cf2) * x * x) % kk;
      g  = (longint'(cf1) + cf2 + 2 * longint'(cf2) * x) % kk;
      v.qf[3*k +: 3] = 3'(pi / m);
      v.qg[3*k +: 3] = 3'(g / m);
      if (k == 0) begin
        v.rf = int'(pi % m);
        v.rg = int'(g % m);
      end
    end
    v.rf2 = int'(((2 * longint'(cf2)) % kk) % m);
    v.qf2 = int'(((2 * longint'(cf2)) % kk) / m);
    return v;
  endfunction

  task automatic check_results(input vec_t v, input string tag);
    check({tag, ".blockSize"},   32'(blockSize),   32'(v.bs));
    check({tag, ".Req_A_Init"},  32'(Req_A_Init),  32'(v.x0));
    check({tag, ".Req_Rf_Init"}, 32'(Req_Rf_Init), 32'(v.rf));
    check({tag, ".Req_Qf_Init"}, 32'(Req_Qf_Init), 32'(v.qf));
    check({tag, ".Req_Rg_Init"}, 32'(Req_Rg_Init), 32'(v.rg));
    check({tag, ".Req_Qg_Init"}, 32'(Req_Qg_Init), 32'(v.qg));
    check({tag, ".Rf2"},         32'(Rf2),         32'(v.rf2));
    check({tag, ".Qf2"},         32'(Qf2),         32'(v.qf2));
  endtask

  // Start a run, scramble the inputs right after, optionally re-pulse start
  // mid-run, and check latency, pulse shape and results.
  task automatic run_vec(input vec_t v, input bit mid_start, input string tag);
    int lat;
    int extra;
    lat   = -1;
    extra = 0;
    @(negedge clk);
    frameLen = 13'(v.kk); f1 = 13'(v.f1); f2 = 13'(v.f2);
    decNum   = 4'(v.dec); startIdx = 13'(v.x0);
    start    = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    frameLen = 13'd17; f1 = 13'd5; f2 = 13'd6; decNum = 4'd1; startIdx = 13'd3;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (Init_flag) begin
        lat = e;
        break;
      end
      if (mid_start && e == 40)
        start = 1'b1;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(3 + 27 * v.dec));
    if (lat > 0) begin
      check({tag, ".busy_off"}, 32'(busy), 32'd0);
      check_results(v, tag);
      @(posedge clk); #1;
      check({tag, ".flag_width"}, 32'(Init_flag), 32'd0);
    end
    if (mid_start) begin
      for (int e = 0; e < 120; e++) begin
        @(posedge clk); #1;
        if (Init_flag || busy) extra++;
      end
      check({tag, ".no_second_run"}, 32'(extra), 32'd0);
    end
    $display("vec %s: K=%0d f1=%0d f2=%0d dec=%0d x0=%0d lat=%0d M=%0d Rf=%0d Qf=%06h Rg=%0d Qg=%06h Rf2=%0d Qf2=%0d",
             tag, v.kk, v.f1, v.f2, v.dec, v.x0, lat, blockSize, Req_Rf_Init,
             Req_Qf_Init, Req_Rg_Init, Req_Qg_Init, Rf2, Qf2);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    reset = 1'b1; start = 1'b0;
    frameLen = '0; f1 = '0; f2 = '0; decNum = '0; startIdx = '0;

    // Hand-computed vectors from the QPP definition, then model-derived ones.
    tbl[0] = '{40, 3, 10, 4, 0, 0, 3, 0, 2, 10, 24'h000298, 24'h000249};
    tbl[1] = '{40, 3, 10, 4, 1, 3, 3, 0, 2, 10, 24'h0004C1, 24'h0006DB};
    tbl[2] = '{6144, 263, 480, 8, 0, 0, 743, 192, 1, 768, 24'h29CBB8, 24'h000000};
    tbl[3] = model(6144, 263, 480, 8, 5);
    tbl[4] = model(248, 33, 62, 2, 7);
    tbl[5] = model(40, 3, 10, 1, 17);

    #23;
    check("reset.busy",   32'(busy),        32'd0);
    check("reset.flag",   32'(Init_flag),   32'd0);
    check("reset.Qf",     32'(Req_Qf_Init), 32'd0);
    check("reset.bs",     32'(blockSize),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i], (i == 1), $sformatf("v%0d", i));

    // Illegal decoder count: single cfg_err pulse, nothing else moves.
    @(negedge clk);
    frameLen = 13'd64; f1 = 13'd7; f2 = 13'd16; decNum = 4'd3; startIdx = 13'd2;
    start = 1'b1;
    @(posedge clk); #1;
    check("cfg.err_pulse", 32'(cfg_err), 32'd1);
    check("cfg.busy",      32'(busy),    32'd0);
    start = 1'b0;
    hits = 0;
    @(posedge clk); #1;
    check("cfg.err_width", 32'(cfg_err), 32'd0);
    for (int e = 0; e < 80; e++) begin
      @(posedge clk); #1;
      if (busy || Init_flag || cfg_err) hits++;
    end
    check("cfg.quiet", 32'(hits), 32'd0);
    check_results(tbl[5], "cfg.hold");
    $display("seq cfg_err: decNum=3 rejected, activity=%0d", hits);

    // Mid-run reset of a decNum=8 run.
    @(negedge clk);
    frameLen = 13'(tbl[2].kk); f1 = 13'(tbl[2].f1); f2 = 13'(tbl[2].f2);
    decNum = 4'd8; startIdx = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e < 50; e++) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst.busy", 32'(busy),        32'd0);
    check("rst.bs",   32'(blockSize),   32'd0);
    check("rst.Qf",   32'(Req_Qf_Init), 32'd0);
    check("rst.Rf2",  32'(Rf2),         32'd0);
    check("rst.Qf2",  32'(Qf2),         32'd0);
    check("rst.A",    32'(Req_A_Init),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int e = 0; e < 250; e++) begin
      @(posedge clk); #1;
      if (Init_flag || busy) hits++;
    end
    check("rst.no_flag", 32'(hits), 32'd0);
    $display("seq reset: aborted dec=8 run, activity after reset=%0d", hits);
    run_vec(tbl[2], 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
